// File: rtl/keypad_hex_entry_if.sv
// Signal bundle between the keypad entry block and the keypad / display side.
// The master drives clr and the row sense lines; the slave is the entry block.
interface keypad_hex_entry_if;
  logic        clr;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [15:0] hexs;
  logic [3:0]  key_code;
  logic        key_pulse;

  modport master (
    output clr,
    output row,
    input  col,
    input  hexs,
    input  key_code,
    input  key_pulse
  );

  modport slave (
    input  clr,
    input  row,
    output col,
    output hexs,
    output key_code,
    output key_pulse
  );
endinterface

// File: rtl/keypad_hex_entry.sv
// Scans a 4x4 active-low keypad, debounces whole-matrix snapshots and shifts each
// accepted single key (code = 4*row + col) into a 16-bit hex entry register.
module keypad_hex_entry #(
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned DEBOUNCE = 4
) (
  input logic              clk,
  input logic              rst_n,
  keypad_hex_entry_if.slave bus
);

  localparam int unsigned CntW = $clog2(SCAN_DIV);
  localparam int unsigned StbW = $clog2(DEBOUNCE + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(SCAN_DIV - 1);
  localparam logic [StbW-1:0] StbMax = StbW'(DEBOUNCE);

  localparam logic [0:0] StArmed   = 1'b0;
  localparam logic [0:0] StLatched = 1'b1;

  logic [3:0]      row_meta_q, row_sync_q;
  logic [CntW-1:0] dwell_cnt_q, dwell_cnt_d;
  logic [1:0]      col_idx_q, col_idx_d;
  logic            sample;
  logic [15:0]     snap_q, snap_d;
  logic [15:0]     prev_snap_q;
  logic            scan_done_q;
  logic [StbW-1:0] stable_cnt_q, stable_cnt_d;
  logic            stable_hit;
  logic [15:0]     stable_keys_q;
  logic            stable_upd_q;
  logic [0:0]      state_q, state_d;
  logic            single_key;
  logic [3:0]      hit_code;
  logic            accept;
  logic [15:0]     hexs_q, hexs_d;
  logic [3:0]      key_code_q;
  logic            key_pulse_q;

  // Rows are asynchronous to clk; idle (pulled-up) value is all ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta_q <= 4'hF;
      row_sync_q <= 4'hF;
    end else begin
      row_meta_q <= bus.row;
      row_sync_q <= row_meta_q;
    end
  end

  assign sample = (dwell_cnt_q == CntMax);

  always_comb begin
    dwell_cnt_d = sample ? '0 : dwell_cnt_q + CntW'(1);
    col_idx_d   = sample ? col_idx_q + 2'd1 : col_idx_q;
    snap_d      = snap_q;
    for (int c = 0; c < 4; c++) begin
      if (sample && (col_idx_q == 2'(c))) begin
        snap_d[4*c +: 4] = ~row_sync_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell_cnt_q <= '0;
      col_idx_q   <= 2'd0;
      snap_q      <= '0;
      scan_done_q <= 1'b0;
    end else begin
      dwell_cnt_q <= dwell_cnt_d;
      col_idx_q   <= col_idx_d;
      snap_q      <= snap_d;
      scan_done_q <= sample && (col_idx_q == 2'd3);
    end
  end

  assign bus.col = ~(4'b0001 << col_idx_q);

  // A full scan is judged in the cycle after column 3 is sampled.
  always_comb begin
    stable_cnt_d = stable_cnt_q;
    if (scan_done_q) begin
      if (snap_q != prev_snap_q) begin
        stable_cnt_d = StbW'(1);
      end else if (stable_cnt_q != StbMax) begin
        stable_cnt_d = stable_cnt_q + StbW'(1);
      end
    end
  end

  assign stable_hit = scan_done_q && (stable_cnt_d == StbMax);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_snap_q   <= '0;
      stable_cnt_q  <= '0;
      stable_keys_q <= '0;
      stable_upd_q  <= 1'b0;
    end else begin
      if (scan_done_q) begin
        prev_snap_q <= snap_q;
      end
      stable_cnt_q <= stable_cnt_d;
      if (stable_hit) begin
        stable_keys_q <= snap_q;
      end
      stable_upd_q <= stable_hit;
    end
  end

  // Snapshot bit 4*c+r holds row r of column c; the key code is 4*r+c.
  always_comb begin
    single_key = (stable_keys_q != '0) && ((stable_keys_q & (stable_keys_q - 16'd1)) == '0);
    hit_code   = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (stable_keys_q[i]) begin
        hit_code = 4'(((i % 4) * 4) + (i / 4));
      end
    end
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    if (stable_upd_q) begin
      case (state_q)
        StArmed: begin
          if (single_key) begin
            accept  = 1'b1;
            state_d = StLatched;
          end
        end
        StLatched: begin
          if (stable_keys_q == '0) begin
            state_d = StArmed;
          end
        end
        default: state_d = StArmed;
      endcase
    end
  end

  // clr takes priority over a same-cycle accept; the strobe still fires.
  always_comb begin
    hexs_d = hexs_q;
    if (bus.clr) begin
      hexs_d = '0;
    end else if (accept) begin
      hexs_d = {hexs_q[11:0], hit_code};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StArmed;
      hexs_q      <= '0;
      key_code_q  <= 4'h0;
      key_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hexs_q      <= hexs_d;
      if (accept) begin
        key_code_q <= hit_code;
      end
      key_pulse_q <= accept;
    end
  end

  assign bus.hexs      = hexs_q;
  assign bus.key_code  = key_code_q;
  assign bus.key_pulse = key_pulse_q;

endmodule

// File: tb/tb_keypad_hex_entry.sv
// Bench for keypad_hex_entry: a keypad model driven one whole scan at a time,
// checked against a scan-level model of debounce, acceptance and entry shifting.
module tb_keypad_hex_entry;

  localparam int unsigned ScanDiv = 4;
  localparam int unsigned Deb     = 2;
  localparam int          Sp      = 4 * ScanDiv;

  typedef struct packed {
    logic [31:0] edge_no;
    logic [3:0]  code;
    logic [15:0] hexs;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] pressed = '0;

  int n_vec = 0;
  int n_err = 0;
  int edge_n = 0;

  ev_t obs_q[$];
  ev_t exp_q[$];

  logic [15:0] hist[$];
  int          scan_idx = 0;
  bit          m_latched = 1'b0;
  logic [15:0] m_hex = '0;
  bit          clr_collide = 1'b0;

  keypad_hex_entry_if bus ();

  keypad_hex_entry #(
    .SCAN_DIV(ScanDiv),
    .DEBOUNCE(Deb)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Physical keypad: a pressed key shorts its row to its column when that column is low.
  always_comb begin
    bus.row = 4'hF;
    for (int k = 0; k < 16; k++) begin
      if (pressed[k] && !bus.col[k % 4]) bus.row[k / 4] = 1'b0;
    end
  end

  always begin
    ev_t e;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      edge_n = 0;
    end else begin
      edge_n++;
      if (bus.key_pulse) begin
        e.edge_no = 32'(edge_n);
        e.code    = bus.key_code;
        e.hexs    = bus.hexs;
        obs_q.push_back(e);
      end
    end
  end

  // Start one scan with the given pressed-key set (bit n = key code n) and
  // predict whether this scan makes a key accepted.
  task automatic scan_start(input logic [15:0] mask);
    bit  stable;
    ev_t e;
    pressed = mask;
    hist.push_back(mask);
    stable = (hist.size() >= Deb);
    for (int i = 1; i < Deb && stable; i++) begin
      if (hist[hist.size() - 1 - i] != mask) stable = 1'b0;
    end
    if (stable) begin
      if (!m_latched && $countones(mask) == 1) begin
        e.code = 4'h0;
        for (int b = 0; b < 16; b++) if (mask[b]) e.code = 4'(b);
        m_latched = 1'b1;
        m_hex     = clr_collide ? 16'h0000 : {m_hex[11:0], e.code};
        e.hexs    = m_hex;
        e.edge_no = 32'(Sp * (scan_idx + 1) + 2);
        exp_q.push_back(e);
      end else if (m_latched && mask == 16'h0) begin
        m_latched = 1'b0;
      end
    end
    scan_idx++;
  endtask

  task automatic wait_scan();
    repeat (Sp) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic hold(input logic [15:0] mask, input int scans);
    for (int s = 0; s < scans; s++) begin
      scan_start(mask);
      wait_scan();
    end
  endtask

  task automatic enter(input int code, input int hold_n, input int rel_n);
    hold(16'(1) << code, hold_n);
    hold(16'h0000, rel_n);
  endtask

  task automatic model_reset();
    hist.delete();
    scan_idx  = 0;
    m_latched = 1'b0;
    m_hex     = '0;
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    logic [3:0] exp_col;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (bus.col !== 4'b1110 || bus.hexs !== 16'h0 || bus.key_pulse !== 1'b0
        || bus.key_code !== 4'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got col %b hexs %h pulse %b code %h, expected 1110 0000 0 0",
               bus.col, bus.hexs, bus.key_pulse, bus.key_code);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int s = 0; s < 2; s++) begin
      scan_start(16'h0000);
      for (int c = 0; c < 4; c++) begin
        exp_col = ~(4'b0001 << c);
        n_vec++;
        if (bus.col !== exp_col) begin
          n_err++;
          $display("FAIL reset_col_step%0d: got col %b, expected %b", s * 4 + c, bus.col, exp_col);
        end
        repeat (ScanDiv) @(posedge clk);
        @(negedge clk);
      end
    end
    n_vec++;
    if (obs_q.size() != 0) begin
      n_err++;
      $display("FAIL reset_idle_pulses: got %0d pulses, expected 0", obs_q.size());
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_single_key();
    hold(16'(1) << 9, 6);
    hold(16'h0000, 3);
    n_vec++;
    if (bus.key_code !== 4'h9 || bus.hexs !== 16'h0009) begin
      n_err++;
      $display("FAIL single_value: got code %h hexs %h, expected 9 0009", bus.key_code, bus.hexs);
    end
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL single_pulses: got %0d pulses, expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_vec++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL single_event%0d: got edge %0d code %h hexs %h, expected edge %0d code %h hexs %h",
                 i, obs_q[i].edge_no, obs_q[i].code, obs_q[i].hexs,
                 exp_q[i].edge_no, exp_q[i].code, exp_q[i].hexs);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_four_digit();
    enter(1, 4, 4);
    enter(10, 4, 4);
    enter(3, 4, 4);
    enter(15, 4, 4);
    n_vec++;
    if (bus.hexs !== 16'h1A3F) begin
      n_err++;
      $display("FAIL four_digit_value: got hexs %h, expected 1a3f", bus.hexs);
    end
    enter(0, 4, 4);
    n_vec++;
    if (bus.hexs !== 16'hA3F0) begin
      n_err++;
      $display("FAIL fifth_digit_value: got hexs %h, expected a3f0", bus.hexs);
    end
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL four_digit_pulses: got %0d pulses, expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_vec++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL four_digit_event%0d: got edge %0d code %h hexs %h, expected edge %0d code %h hexs %h",
                 i, obs_q[i].edge_no, obs_q[i].code, obs_q[i].hexs,
                 exp_q[i].edge_no, exp_q[i].code, exp_q[i].hexs);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_chord_bounce();
    hold((16'(1) << 5) | (16'(1) << 6), 4);
    hold(16'h0000, 3);
    hold(16'(1) << 7, 2);
    hold(16'h0000, 1);
    hold(16'(1) << 7, 3);
    hold(16'h0000, 3);
    n_vec++;
    if (bus.key_code !== 4'h7) begin
      n_err++;
      $display("FAIL bounce_code: got code %h, expected 7", bus.key_code);
    end
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL chord_bounce_pulses: got %0d pulses, expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_vec++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL chord_bounce_event%0d: got edge %0d code %h hexs %h, expected edge %0d code %h hexs %h",
                 i, obs_q[i].edge_no, obs_q[i].code, obs_q[i].hexs,
                 exp_q[i].edge_no, exp_q[i].code, exp_q[i].hexs);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_clear_collision();
    for (int d = 1; d <= 4; d++) enter(d, 2, 2);
    n_vec++;
    if (bus.hexs !== 16'h1234) begin
      n_err++;
      $display("FAIL pre_clear_value: got hexs %h, expected 1234", bus.hexs);
    end
    // One-cycle clear inside an idle scan, keeping scan alignment.
    scan_start(16'h0000);
    bus.clr = 1'b1;
    @(posedge clk);
    #1;
    m_hex = '0;
    n_vec++;
    if (bus.hexs !== 16'h0000 || bus.key_code !== 4'h4) begin
      n_err++;
      $display("FAIL clear_value: got hexs %h code %h, expected 0000 4", bus.hexs, bus.key_code);
    end
    @(negedge clk);
    bus.clr = 1'b0;
    repeat (Sp - 1) @(posedge clk);
    @(negedge clk);
    // Key B accepted two edges into the following scan; clr lands on that edge.
    scan_start(16'(1) << 11);
    wait_scan();
    clr_collide = 1'b1;
    scan_start(16'(1) << 11);
    clr_collide = 1'b0;
    wait_scan();
    scan_start(16'h0000);
    @(posedge clk);
    @(negedge clk);
    bus.clr = 1'b1;
    @(posedge clk);
    #1;
    n_vec++;
    if (bus.hexs !== 16'h0000 || bus.key_pulse !== 1'b1 || bus.key_code !== 4'hB) begin
      n_err++;
      $display("FAIL clr_collision: got hexs %h pulse %b code %h, expected 0000 1 b",
               bus.hexs, bus.key_pulse, bus.key_code);
    end
    @(negedge clk);
    bus.clr = 1'b0;
    repeat (Sp - 2) @(posedge clk);
    @(negedge clk);
    hold(16'h0000, 2);
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL clear_pulses: got %0d pulses, expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_vec++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL clear_event%0d: got edge %0d code %h hexs %h, expected edge %0d code %h hexs %h",
                 i, obs_q[i].edge_no, obs_q[i].code, obs_q[i].hexs,
                 exp_q[i].edge_no, exp_q[i].code, exp_q[i].hexs);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_random();
    for (int it = 0; it < 24; it++) begin
      int          kind;
      logic [15:0] m;
      kind = int'($urandom_range(0, 3));
      case (kind)
        0:       m = 16'h0000;
        3:       m = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
        default: m = 16'(1) << $urandom_range(0, 15);
      endcase
      hold(m, int'($urandom_range(1, 4)));
    end
    hold(16'h0000, 3);
    n_vec++;
    if (bus.hexs !== m_hex) begin
      n_err++;
      $display("FAIL random_final_hexs: got %h, expected %h", bus.hexs, m_hex);
    end
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL random_pulses: got %0d pulses, expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_vec++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL random_event%0d: got edge %0d code %h hexs %h, expected edge %0d code %h hexs %h",
                 i, obs_q[i].edge_no, obs_q[i].code, obs_q[i].hexs,
                 exp_q[i].edge_no, exp_q[i].code, exp_q[i].hexs);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset_mid_debounce();
    scan_start(16'(1) << 4);
    wait_scan();
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (bus.col !== 4'b1110 || bus.hexs !== 16'h0 || bus.key_pulse !== 1'b0
        || bus.key_code !== 4'h0) begin
      n_err++;
      $display("FAIL mid_reset_outputs: got col %b hexs %h pulse %b code %h, expected 1110 0000 0 0",
               bus.col, bus.hexs, bus.key_pulse, bus.key_code);
    end
    n_vec++;
    if (obs_q.size() != 0) begin
      n_err++;
      $display("FAIL mid_reset_early_pulse: got %0d pulses, expected 0", obs_q.size());
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    hold(16'(1) << 4, 3);
    hold(16'h0000, 3);
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL mid_reset_pulses: got %0d pulses, expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_vec++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL mid_reset_event%0d: got edge %0d code %h hexs %h, expected edge %0d code %h hexs %h",
                 i, obs_q[i].edge_no, obs_q[i].code, obs_q[i].hexs,
                 exp_q[i].edge_no, exp_q[i].code, exp_q[i].hexs);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    bus.clr = 1'b0;
    test_reset();
    test_single_key();
    test_four_digit();
    test_chord_bounce();
    test_clear_collision();
    test_random();
    test_reset_mid_debounce();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
